// File: rtl/uart_rx_word_packer_pkg.sv
// Shared UART constants and packer types for the receive word packer.
package uart_rx_word_packer_pkg;

  localparam int UART_CLKS_PER_BIT = 87;
  localparam int UART_WORD_BYTES   = 4;
  localparam int UART_BYTE_W       = 8;
  localparam int UART_WORD_W       = UART_WORD_BYTES * UART_BYTE_W;
  localparam int UART_CNT_W        = 2;

  typedef enum logic {
    PACK_EMPTY = 1'b0,
    PACK_FILL  = 1'b1
  } pack_state_t;

endpackage

// File: rtl/uart_rx_word_packer_sync_fifo.sv
// First-word fall-through synchronous FIFO; head reads as 0 while empty.
module uart_rx_word_packer_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  // A full FIFO still accepts a write when the same cycle pops the head.
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? {WIDTH{1'b0}} : mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs uart_rx bytes into 32-bit words (LSB byte first) and queues them in a word FIFO.
// Optional partial-word timeout: define UART_RX_PACK_TIMEOUT_EN.
module uart_rx_word_packer
  import uart_rx_word_packer_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_CLKS = 40 * UART_CLKS_PER_BIT
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   i_Rx_DV,
  input  logic [UART_BYTE_W-1:0] i_Rx_Byte,
  input  logic                   i_Rd_En,
  input  logic                   i_Clr_Err,
  output logic [UART_WORD_W-1:0] o_Word,
  output logic                   o_Word_Valid,
  output logic                   o_Fifo_Full,
  output logic [UART_CNT_W-1:0]  o_Byte_Cnt,
  output logic                   o_Overflow,
  output logic                   o_Timeout
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CLKS < 1)) begin : g_bad_cfg
    $error("uart_rx_word_packer: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CLKS >= 1");
  end

  pack_state_t            state;
  pack_state_t            state_nxt;
  logic [UART_CNT_W-1:0]  cnt;
  logic [UART_CNT_W-1:0]  cnt_nxt;
  logic [UART_WORD_W-1:0] asm_word;
  logic [UART_WORD_W-1:0] asm_nxt;
  logic [UART_WORD_W-1:0] push_word;
  logic                   push;
  logic                   timeout_hit;
  logic                   ovf_set;
  logic                   fifo_empty;
  logic                   fifo_full;

`ifdef UART_RX_PACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Idle clocks since the last byte of a partial word; fires TIMEOUT_CLKS clocks after it.
  assign timeout_hit = (state == PACK_FILL) && (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      tmo_cnt <= '0;
    end else if (i_Rx_DV || (state == PACK_EMPTY) || timeout_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Packer next state: a timeout discards the partial word, and a byte in that cycle is byte 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    asm_nxt   = asm_word;
    push      = 1'b0;
    push_word = {UART_WORD_W{1'b0}};
    if (timeout_hit) begin
      if (i_Rx_DV) begin
        state_nxt = PACK_FILL;
        cnt_nxt   = UART_CNT_W'(1);
        asm_nxt   = {{(UART_WORD_W-UART_BYTE_W){1'b0}}, i_Rx_Byte};
      end else begin
        state_nxt = PACK_EMPTY;
        cnt_nxt   = '0;
        asm_nxt   = {UART_WORD_W{1'b0}};
      end
    end else if (i_Rx_DV) begin
      if (cnt == UART_CNT_W'(UART_WORD_BYTES - 1)) begin
        push      = 1'b1;
        push_word = {i_Rx_Byte, asm_word[UART_WORD_W-UART_BYTE_W-1:0]};
        state_nxt = PACK_EMPTY;
        cnt_nxt   = '0;
        asm_nxt   = {UART_WORD_W{1'b0}};
      end else begin
        asm_nxt[{cnt, 3'b000} +: UART_BYTE_W] = i_Rx_Byte;
        state_nxt = PACK_FILL;
        cnt_nxt   = cnt + UART_CNT_W'(1);
      end
    end else begin
      state_nxt = state;
    end
  end

  // Packer state, byte count and assembly register.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state    <= PACK_EMPTY;
      cnt      <= '0;
      asm_word <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      asm_word <= asm_nxt;
    end
  end

  // A full FIFO is never empty, so a coinciding read always frees a slot.
  assign ovf_set = push && fifo_full && !i_Rd_En;

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      o_Overflow <= 1'b0;
      o_Timeout  <= 1'b0;
    end else begin
      if (ovf_set)        o_Overflow <= 1'b1;
      else if (i_Clr_Err) o_Overflow <= 1'b0;
      else                o_Overflow <= o_Overflow;
      if (timeout_hit)    o_Timeout  <= 1'b1;
      else if (i_Clr_Err) o_Timeout  <= 1'b0;
      else                o_Timeout  <= o_Timeout;
    end
  end

  uart_rx_word_packer_sync_fifo #(
    .WIDTH (UART_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_Clock),
    .rst_n   (i_Rst_n),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (i_Rd_En),
    .rd_data (o_Word),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign o_Word_Valid = !fifo_empty;
  assign o_Fifo_Full  = fifo_full;
  assign o_Byte_Cnt   = cnt;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer; byte strobes are driven directly.
`timescale 1ns/1ps
module tb_uart_rx_word_packer;

  localparam int DEPTH = 4;
  localparam int TMO   = 3480;

  logic        i_Clock = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_Rx_DV = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'h00;
  logic        i_Rd_En = 1'b0;
  logic        i_Clr_Err = 1'b0;
  logic [31:0] o_Word;
  logic        o_Word_Valid;
  logic        o_Fifo_Full;
  logic [1:0]  o_Byte_Cnt;
  logic        o_Overflow;
  logic        o_Timeout;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  part[$];
  logic [31:0] fifo_q[$];
  logic        m_ovf = 1'b0;
  logic        m_tmo = 1'b0;
  longint      cyc = 0;
  longint      last_dv = 0;

  uart_rx_word_packer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .i_Rd_En(i_Rd_En), .i_Clr_Err(i_Clr_Err), .o_Word(o_Word), .o_Word_Valid(o_Word_Valid),
    .o_Fifo_Full(o_Fifo_Full), .o_Byte_Cnt(o_Byte_Cnt), .o_Overflow(o_Overflow),
    .o_Timeout(o_Timeout)
  );

  always #50 i_Clock = ~i_Clock;

  function automatic void model_step(input logic dv, input logic [7:0] b, input logic rd,
                                     input logic clr);
    bit ovf_set = 1'b0;
    bit tmo_set = 1'b0;
    cyc++;
    if (!i_Rst_n) begin
      part.delete();
      fifo_q.delete();
      m_ovf = 1'b0;
      m_tmo = 1'b0;
      return;
    end
`ifdef UART_RX_PACK_TIMEOUT_EN
    if (part.size() != 0 && (cyc - last_dv) == longint'(TMO)) begin
      part.delete();
      tmo_set = 1'b1;
    end
`endif
    if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (dv) begin
      part.push_back(b);
      last_dv = cyc;
      if (part.size() == 4) begin
        if (fifo_q.size() < DEPTH) fifo_q.push_back({part[3], part[2], part[1], part[0]});
        else ovf_set = 1'b1;
        part.delete();
      end
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (tmo_set) m_tmo = 1'b1;
    else if (clr) m_tmo = 1'b0;
  endfunction

  function automatic logic [37:0] model_outs();
    logic [31:0] w;
    w = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    return {w, fifo_q.size() != 0, fifo_q.size() == DEPTH, 2'(part.size()), m_ovf, m_tmo};
  endfunction

  task automatic step(input logic dv, input logic [7:0] b, input logic rd, input logic clr);
    i_Rx_DV = dv; i_Rx_Byte = b; i_Rd_En = rd; i_Clr_Err = clr;
    model_step(dv, b, rd, clr);
    @(posedge i_Clock);
    #1;
    i_Rx_DV = 1'b0; i_Rd_En = 1'b0; i_Clr_Err = 1'b0;
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0;
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    i_Rst_n = 1'b1;
    checks++;
    if ({o_Word, o_Word_Valid, o_Fifo_Full, o_Byte_Cnt, o_Overflow, o_Timeout} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs: got word=%h v=%b f=%b cnt=%0d ovf=%b tmo=%b, want all 0",
               o_Word, o_Word_Valid, o_Fifo_Full, o_Byte_Cnt, o_Overflow, o_Timeout);
    end
  endtask

  task automatic test_single_word();
    step(1'b1, 8'h78, 1'b0, 1'b0);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b0);
    checks++;
    if (o_Byte_Cnt !== 2'd3 || o_Word_Valid !== 1'b0) begin
      errors++;
      $display("FAIL single_partial: cnt=%0d valid=%b, want cnt=3 valid=0", o_Byte_Cnt, o_Word_Valid);
    end
    step(1'b1, 8'h12, 1'b0, 1'b0);
    checks++;
    if (o_Word !== 32'h12345678 || o_Word_Valid !== 1'b1 || o_Byte_Cnt !== 2'd0) begin
      errors++;
      $display("FAIL single_word: word=%h valid=%b cnt=%0d, want 12345678 1 0",
               o_Word, o_Word_Valid, o_Byte_Cnt);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (o_Word !== 32'h0 || o_Word_Valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: word=%h valid=%b, want 0 0", o_Word, o_Word_Valid);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] sent[5];
    for (int w = 0; w < 5; w++) begin
      sent[w] = $urandom;
      for (int k = 0; k < 4; k++) step(1'b1, sent[w][8*k +: 8], 1'b0, 1'b0);
    end
    checks++;
    if (o_Fifo_Full !== 1'b1 || o_Overflow !== 1'b1 || o_Word !== sent[0]) begin
      errors++;
      $display("FAIL overflow_flags: full=%b ovf=%b head=%h, want 1 1 %h",
               o_Fifo_Full, o_Overflow, o_Word, sent[0]);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (o_Overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: ovf=%b, want 0", o_Overflow);
    end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (o_Word !== sent[w]) begin
        errors++;
        $display("FAIL overflow_order[%0d]: got %h, want %h", w, o_Word, sent[w]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] sent[5];
    for (int w = 0; w < 5; w++) begin
      sent[w] = $urandom;
      for (int k = 0; k < 4; k++) step(1'b1, sent[w][8*k +: 8], (w == 4 && k == 3), 1'b0);
    end
    checks++;
    if (o_Overflow !== 1'b0 || o_Fifo_Full !== 1'b1 || o_Word !== sent[1]) begin
      errors++;
      $display("FAIL full_push_pop: ovf=%b full=%b head=%h, want 0 1 %h",
               o_Overflow, o_Fifo_Full, o_Word, sent[1]);
    end
    for (int w = 1; w < 5; w++) begin
      checks++;
      if (o_Word !== sent[w]) begin
        errors++;
        $display("FAIL full_push_pop_order[%0d]: got %h, want %h", w, o_Word, sent[w]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

`ifdef UART_RX_PACK_TIMEOUT_EN
  task automatic test_timeout();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (o_Byte_Cnt !== 2'd2 || o_Timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: cnt=%0d tmo=%b, want 2 0", o_Byte_Cnt, o_Timeout);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (o_Byte_Cnt !== 2'd0 || o_Timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: cnt=%0d tmo=%b, want 0 1", o_Byte_Cnt, o_Timeout);
    end
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b0);
    checks++;
    if (o_Word !== 32'hDDCCBBAA || o_Timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next_word: word=%h tmo=%b, want ddccbbaa 0", o_Word, o_Timeout);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    checks++;
    if (o_Byte_Cnt !== 2'd1 || o_Timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_same_cycle_byte: cnt=%0d tmo=%b, want 1 1", o_Byte_Cnt, o_Timeout);
    end
    step(1'b1, 8'h6B, 1'b0, 1'b1);
    step(1'b1, 8'h7C, 1'b0, 1'b0);
    step(1'b1, 8'h8D, 1'b0, 1'b0);
    checks++;
    if (o_Word !== 32'h8D7C6B5A) begin
      errors++;
      $display("FAIL timeout_restart_word: got %h, want 8d7c6b5a", o_Word);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_reset_midword();
    for (int i = 0; i < 11; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    i_Rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    i_Rst_n = 1'b1;
    checks++;
    if ({o_Word, o_Word_Valid, o_Fifo_Full, o_Byte_Cnt, o_Overflow, o_Timeout} !== 38'h0) begin
      errors++;
      $display("FAIL reset_midword: word=%h v=%b cnt=%0d, want all 0", o_Word, o_Word_Valid, o_Byte_Cnt);
    end
    step(1'b1, 8'hEF, 1'b0, 1'b0);
    step(1'b1, 8'hBE, 1'b0, 1'b0);
    step(1'b1, 8'hAD, 1'b0, 1'b0);
    step(1'b1, 8'hDE, 1'b0, 1'b0);
    checks++;
    if (o_Word !== 32'hDEADBEEF || o_Fifo_Full !== 1'b0) begin
      errors++;
      $display("FAIL reset_fresh_word: word=%h full=%b, want deadbeef 0", o_Word, o_Fifo_Full);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_empty_read();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (o_Word !== 32'h0 || o_Word_Valid !== 1'b0 || o_Overflow !== 1'b0 || o_Timeout !== 1'b0) begin
      errors++;
      $display("FAIL empty_read: word=%h v=%b ovf=%b tmo=%b, want 0 0 0 0",
               o_Word, o_Word_Valid, o_Overflow, o_Timeout);
    end
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b0);
    checks++;
    if (o_Word !== 32'h04030201 || o_Word_Valid !== 1'b1) begin
      errors++;
      $display("FAIL empty_read_then_push: word=%h v=%b, want 04030201 1", o_Word, o_Word_Valid);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [37:0] exp_v;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 55), 8'($urandom), ($urandom_range(99) < 20),
           ($urandom_range(99) < 5));
      exp_v = model_outs();
      checks++;
      if ({o_Word, o_Word_Valid, o_Fifo_Full, o_Byte_Cnt, o_Overflow, o_Timeout} !== exp_v) begin
        errors++;
        $display("FAIL random[%0d]: got word=%h v=%b f=%b cnt=%0d ovf=%b tmo=%b, want %h %b %b %0d %b %b",
                 i, o_Word, o_Word_Valid, o_Fifo_Full, o_Byte_Cnt, o_Overflow, o_Timeout,
                 exp_v[37:6], exp_v[5], exp_v[4], exp_v[3:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_word();
    test_overflow();
    test_full_push_pop();
`ifdef UART_RX_PACK_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midword();
    test_empty_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
